mode_launch_ctrl: RTL and testbench

- Upstream control stage for the vector processor.
- Takes raw operator inputs from board switches and the start button, then synchronises, debounces and validates them.
- Drives exactly one registered, one-hot mode line into the processor: xor, rshift, lshift, ecae, dcae or mul.
- Holds that mode stable for the whole processing run, then waits for the processor's completion pulse and for button release before re-arming.

---
 rtl/asip_ctrl_pkg.sv | 28 ++
 rtl/btn_debounce.sv | 58 +++++
 rtl/mode_launch_ctrl.sv | 153 +++++++++++++++
 tb/tb_mode_launch_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/asip_ctrl_pkg.sv
// Shared types and constants for the ASIP operator control path.
// Launch FSM states, mode bit indices and a one-hot helper.
package asip_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RELEASE
  } launch_state_t;

  localparam int NUM_MODES   = 6;
  localparam int MODE_XOR    = 0;
  localparam int MODE_RSHIFT = 1;
  localparam int MODE_LSHIFT = 2;
  localparam int MODE_ECAE   = 3;
  localparam int MODE_DCAE   = 4;
  localparam int MODE_MUL    = 5;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(
    input logic [NUM_MODES-1:0] v
  );
    logic [NUM_MODES-1:0] low;
    low = v - NUM_MODES'(1);
    return (v != '0) && ((v & low) == '0);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: synchroniser, debounce counter, rising-edge pulse.
// Ports: clk, reset (async low), btn_raw in; btn_db level, rise pulse out.
module btn_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_db,
  output logic rise
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   db_q;
  logic                   db_d1_q;
  logic                   btn_sync;

  assign btn_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
    end
  end

  // Counter only runs while the synced level disagrees
  // with the debounced one; any agreement restarts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      db_q    <= 1'b0;
      db_d1_q <= 1'b0;
    end else begin
      db_d1_q <= db_q;
      if (btn_sync == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        db_q  <= ~db_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign btn_db = db_q;
  assign rise   = db_q & ~db_d1_q;

endmodule

// File: rtl/mode_launch_ctrl.sv
// Operator launch control: validates switches on start, drives one mode.
// Ports: clk, reset, sw_mode, btn_start, proc_done in; mode_*, busy, err_* out.
module mode_launch_ctrl
  import asip_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_MODES-1:0] sw_mode,
  input  logic                 btn_start,
  input  logic                 proc_done,
  output logic                 mode_xor,
  output logic                 mode_rshift,
  output logic                 mode_lshift,
  output logic                 mode_ecae,
  output logic                 mode_dcae,
  output logic                 mode_mul,
  output logic                 busy,
  output logic                 err_invalid,
  output logic                 err_timeout
);

  localparam int RW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [RW-1:0] RUN_LAST =
    RW'(TIMEOUT_CYCLES - 1);
  localparam logic TO_EN = (TIMEOUT_CYCLES != 0);

  logic [SYNC_STAGES-1:0][NUM_MODES-1:0] sw_sync_q;
  logic [NUM_MODES-1:0] sw_sync;
  logic                 sw_valid;
  logic                 btn_db;
  logic                 start_evt;

  launch_state_t        state_q;
  launch_state_t        state_d;
  logic [RW-1:0]        run_cnt_q;
  logic [NUM_MODES-1:0] mode_q;
  logic                 err_inv_q;
  logic                 err_to_q;
  logic                 timeout_hit;

  btn_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_start_btn (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_start),
    .btn_db  (btn_db),
    .rise    (start_evt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_sync_q <= '0;
    end else begin
      sw_sync_q[0] <= sw_mode;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sw_sync_q[i] <= sw_sync_q[i-1];
      end
    end
  end

  assign sw_sync  = sw_sync_q[SYNC_STAGES-1];
  assign sw_valid = is_onehot(sw_sync);

  assign timeout_hit = TO_EN && (run_cnt_q == RUN_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_evt && sw_valid) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (proc_done || timeout_hit) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!btn_db) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Mode latch, run timer and sticky flags. proc_done is
  // checked first so a coincident timeout is not flagged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q    <= '0;
      run_cnt_q <= '0;
      err_inv_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_evt) begin
            if (sw_valid) begin
              mode_q    <= sw_sync;
              run_cnt_q <= '0;
              err_inv_q <= 1'b0;
              err_to_q  <= 1'b0;
            end else begin
              err_inv_q <= 1'b1;
            end
          end
        end
        RUN: begin
          run_cnt_q <= run_cnt_q + 1'b1;
          if (proc_done) begin
            mode_q <= '0;
          end else if (timeout_hit) begin
            mode_q   <= '0;
            err_to_q <= 1'b1;
          end
        end
        default: begin
          mode_q <= '0;
        end
      endcase
    end
  end

  always_comb begin
    busy        = (state_q != IDLE);
    mode_xor    = mode_q[MODE_XOR];
    mode_rshift = mode_q[MODE_RSHIFT];
    mode_lshift = mode_q[MODE_LSHIFT];
    mode_ecae   = mode_q[MODE_ECAE];
    mode_dcae   = mode_q[MODE_DCAE];
    mode_mul    = mode_q[MODE_MUL];
    err_invalid = err_inv_q;
    err_timeout = err_to_q;
  end

endmodule

// File: tb/tb_mode_launch_ctrl.sv
// Bench for mode_launch_ctrl: directed plan plus random presses.
// Outputs compared each cycle against a behavioural model.
module tb_mode_launch_ctrl;

  localparam int SS = 2;
  localparam int DB = 4;
  localparam int TO = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] sw_mode = '0;
  logic       btn_start = 1'b0;
  logic       proc_done = 1'b0;
  logic       mode_xor, mode_rshift, mode_lshift;
  logic       mode_ecae, mode_dcae, mode_mul;
  logic       busy, err_invalid, err_timeout;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mode_launch_ctrl #(
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DB),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sw_mode     (sw_mode),
    .btn_start   (btn_start),
    .proc_done   (proc_done),
    .mode_xor    (mode_xor),
    .mode_rshift (mode_rshift),
    .mode_lshift (mode_lshift),
    .mode_ecae   (mode_ecae),
    .mode_dcae   (mode_dcae),
    .mode_mul    (mode_mul),
    .busy        (busy),
    .err_invalid (err_invalid),
    .err_timeout (err_timeout)
  );

  // Model: input delay lines, run-length debounce, and
  // flags running/releasing with a mode index.
  bit         q_b[$];
  logic [5:0] q_sw[$];
  bit         m_db;
  int         m_diff;
  bit         m_evt;
  bit         m_run;
  bit         m_rel;
  int         m_mi;
  int         m_len;
  bit         m_einv;
  bit         m_eto;

  function automatic void model_reset();
    q_b.delete();
    q_sw.delete();
    for (int i = 0; i < SS; i++) begin
      q_b.push_back(1'b0);
      q_sw.push_back(6'd0);
    end
    m_db = 0; m_diff = 0; m_evt = 0;
    m_run = 0; m_rel = 0; m_mi = 0; m_len = 0;
    m_einv = 0; m_eto = 0;
  endfunction

  function automatic void model_edge();
    bit         bs;
    logic [5:0] ss;
    bit         evt;
    if (!reset) begin
      model_reset();
      return;
    end
    bs  = q_b[0];
    ss  = q_sw[0];
    evt = m_evt;
    q_b.push_back(btn_start);
    void'(q_b.pop_front());
    q_sw.push_back(sw_mode);
    void'(q_sw.pop_front());
    if (m_run) begin
      if (proc_done) begin
        m_run = 0; m_rel = 1;
      end else if (m_len + 1 == TO) begin
        m_run = 0; m_rel = 1; m_eto = 1;
      end else begin
        m_len++;
      end
    end else if (m_rel) begin
      if (!m_db) m_rel = 0;
    end else if (evt) begin
      if ($countones(ss) == 1) begin
        m_run = 1; m_len = 0; m_einv = 0; m_eto = 0;
        for (int i = 0; i < 6; i++)
          if (ss[i]) m_mi = i;
      end else begin
        m_einv = 1;
      end
    end
    m_evt = 0;
    if (bs != m_db) begin
      m_diff++;
      if (m_diff == DB) begin
        m_db = !m_db;
        m_diff = 0;
        m_evt = m_db;
      end
    end else begin
      m_diff = 0;
    end
  endfunction

  function automatic logic [8:0] model_exp();
    logic [5:0] m;
    m = m_run ? 6'(1 << m_mi) : 6'd0;
    return {m_eto, m_einv, (m_run | m_rel), m};
  endfunction

  function automatic logic [8:0] dut_obs();
    return {err_timeout, err_invalid, busy,
            mode_mul, mode_dcae, mode_ecae,
            mode_lshift, mode_rshift, mode_xor};
  endfunction

  task automatic check(input string tag);
    logic [8:0] obs;
    logic [8:0] exp;
    obs = dut_obs();
    exp = model_exp();
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s obs=%b exp=%b t=%0t", tag, obs, exp, $time);
    end
    vectors++;
    assert ($countones(obs[5:0]) <= 1) else begin
      miscompares++;
      $error("FAIL %s_onehot obs=%b exp=<=1 hot t=%0t",
             tag, obs[5:0], $time);
    end
  endtask

  task automatic dchk(input string tag,
                      input logic [8:0] obs,
                      input logic [8:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s obs=%b exp=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int n, input string tag);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check(tag);
    end
  endtask

  task automatic pulse_done(input string tag);
    proc_done = 1'b1;
    step(1, tag);
    proc_done = 1'b0;
  endtask

  task automatic rstep(input int n);
    repeat (n) begin
      proc_done = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) sw_mode = 6'($urandom);
      step(1, "rnd");
    end
    proc_done = 1'b0;
  endtask

  initial begin
    model_reset();
    #1 reset = 1'b0;
    #1 check("reset");
    dchk("reset_outs", dut_obs(), 9'd0);
    step(3, "reset");
    reset = 1'b1;
    step(2, "idle");

    // 1: clean press, rshift after 7 edges
    sw_mode = 6'b000010;
    btn_start = 1'b1;
    step(6, "t1");
    dchk("t1_pre", 9'(mode_rshift), 9'd0);
    step(1, "t1");
    dchk("t1_rise", dut_obs(), 9'b001_000010);
    step(3, "t1");
    btn_start = 1'b0;
    pulse_done("t1");
    step(12, "t1");
    dchk("t1_idle", 9'(busy), 9'd0);

    // 2: bouncy button is filtered
    sw_mode = 6'b000001;
    repeat (3) begin
      btn_start = 1'b1;
      step(2, "t2");
      btn_start = 1'b0;
      step(2, "t2");
    end
    step(10, "t2");
    dchk("t2_quiet", dut_obs(), 9'd0);

    // 3: invalid then valid start
    sw_mode = 6'b000101;
    btn_start = 1'b1;
    step(10, "t3");
    btn_start = 1'b0;
    step(8, "t3");
    dchk("t3_inv", dut_obs(), 9'b010_000000);
    sw_mode = 6'b100000;
    btn_start = 1'b1;
    step(7, "t3");
    dchk("t3_mul", dut_obs(), 9'b001_100000);
    step(3, "t3");
    btn_start = 1'b0;
    pulse_done("t3");
    step(12, "t3");

    // 4: sw change ignored, done while button held
    sw_mode = 6'b000001;
    btn_start = 1'b1;
    step(7, "t4");
    sw_mode = 6'b001000;
    step(19, "t4");
    dchk("t4_hold", 9'({mode_xor, mode_ecae}), 9'b10);
    pulse_done("t4");
    dchk("t4_fall", 9'({mode_xor, busy}), 9'b01);
    step(10, "t4");
    dchk("t4_held", 9'(busy), 9'd1);
    btn_start = 1'b0;
    step(6, "t4");
    dchk("t4_rel", 9'(busy), 9'd1);
    step(1, "t4");
    dchk("t4_idle", 9'(busy), 9'd0);

    // 5: timeout, late done ignored, next start clears
    sw_mode = 6'b000100;
    btn_start = 1'b1;
    step(7, "t5");
    step(3, "t5");
    btn_start = 1'b0;
    step(46, "t5");
    dchk("t5_run49", 9'({mode_lshift, err_timeout}), 9'b10);
    step(1, "t5");
    dchk("t5_to", 9'({mode_lshift, err_timeout}), 9'b01);
    pulse_done("t5");
    step(2, "t5");
    dchk("t5_late", 9'({busy, err_timeout}), 9'b01);
    sw_mode = 6'b010000;
    btn_start = 1'b1;
    step(7, "t5");
    dchk("t5_clr", dut_obs(), 9'b001_010000);
    btn_start = 1'b0;
    pulse_done("t5");
    step(10, "t5");

    // 6: async reset mid-run
    sw_mode = 6'b001000;
    btn_start = 1'b1;
    step(7, "t6");
    dchk("t6_ecae", 9'(mode_ecae), 9'd1);
    btn_start = 1'b0;
    step(2, "t6");
    #2 reset = 1'b0;
    #1 dchk("t6_async", dut_obs(), 9'd0);
    model_reset();
    step(3, "t6");
    reset = 1'b1;
    step(10, "t6");
    dchk("t6_idle", dut_obs(), 9'd0);
    btn_start = 1'b1;
    step(7, "t6");
    dchk("t6_again", 9'(mode_ecae), 9'd1);
    btn_start = 1'b0;
    pulse_done("t6");
    step(10, "t6");

    // random presses, bounce, switches and done pulses
    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 2) != 0)
        sw_mode = 6'(1 << $urandom_range(0, 5));
      else
        sw_mode = 6'($urandom);
      repeat ($urandom_range(0, 4)) begin
        btn_start = 1'($urandom_range(0, 1));
        rstep($urandom_range(1, 3));
      end
      btn_start = 1'b1;
      rstep($urandom_range(2, 25));
      btn_start = 1'b0;
      rstep($urandom_range(2, 70));
    end
    step(5, "tail");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
